// File: rtl/acumulador_4bit_ctrl.sv
// Sequential wrapper around a combinational 4-bit adder: registers operands, captures
// sum/carry, optionally accumulates, counts carry-outs and hands results downstream.
module acumulador_4bit_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  input  logic             in_acc,
  input  logic             clr_acc,
  output logic [WIDTH-1:0] Op_A,
  output logic [WIDTH-1:0] Op_B,
  input  logic [WIDTH-1:0] Sum_in,
  input  logic             Cout_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Carry,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] ovf_count,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_OUT     = 2'd2;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready depends only on state (and reset), out_valid only on state.
  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] op_a_q,   op_a_d;
  logic [WIDTH-1:0] op_b_q,   op_b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q,  carry_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [CNT_W-1:0] ovf_q,    ovf_d;
  logic             accept;

  assign in_ready  = rst_n & (state_q == S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    carry_d  = carry_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          // A same-edge clear wins over feeding the old accumulator back.
          op_a_d  = in_acc ? (clr_acc ? '0 : acc_q) : in_A;
          op_b_d  = in_B;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        result_d = Sum_in;
        carry_d  = Cout_in;
        acc_d    = Sum_in;
        if (Cout_in && (ovf_q != {CNT_W{1'b1}})) ovf_d = ovf_q + CNT_W'(1);
        state_d  = S_OUT;
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (clr_acc) begin
      acc_d = '0;
      ovf_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
    end
  end

  assign Op_A      = op_a_q;
  assign Op_B      = op_b_q;
  assign Result    = result_q;
  assign Carry     = carry_q;
  assign acc       = acc_q;
  assign ovf_count = ovf_q;
  assign state_dbg = state_q;

endmodule
